iiitb_fifo_drain: RTL and testbench



---
 rtl/iiitb_fifo_drain.sv | 141 ++++++++++++++
 tb/tb_iiitb_fifo_drain.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_fifo_drain.sv
// iiitb_fifo_drain: bursts reads out of iiitb_fifo and re-times them through a 4-entry buffer onto a valid/ready stream.
// Optional accepted-word sequence checker: define IIITB_FIFO_DRAIN_SEQ_CHECK_EN.
module iiitb_fifo_drain #(
    parameter int DATA_WIDTH         = 8,
    parameter int BURST_LEN          = 16,
    parameter int START_ON_THRESHOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_threshold,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  burst_done,
    output logic [15:0]           word_count,
    output logic                  seq_err
);
    // state | meaning
    // IDLE  | waiting for enable and the start condition
    // DRAIN | issuing reads, limited by burst length and buffer credit
    // FLUSH | no new reads; waiting for in-flight and buffered words to leave
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    state_t                state, state_nxt;
    logic [7:0]            issued;
    logic                  rd_q;
    logic [DATA_WIDTH-1:0] fifo_buf [4];
    logic [1:0]            wr_ptr, rd_ptr;
    logic [2:0]            occ;
    logic                  start_cond, pop, clr_issued;

    assign start_cond = (START_ON_THRESHOLD != 0) ? fifo_threshold : ~fifo_empty;
    assign m_valid    = (occ != 3'd0);
    assign m_data     = fifo_buf[rd_ptr];
    assign pop        = m_valid & m_ready;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt  = state;
        fifo_rd    = 1'b0;
        burst_done = 1'b0;
        clr_issued = 1'b0;
        case (state)
            IDLE: begin
                if (enable && start_cond) begin
                    state_nxt  = DRAIN;
                    clr_issued = 1'b1;
                end
            end
            DRAIN: begin
                // occ + rd_q counts every word already committed to the buffer
                fifo_rd = ~fifo_empty & ((occ + {2'b00, rd_q}) < 3'd4)
                        & (issued < BURST_MAX) & enable;
                if (!enable || (fifo_empty && !fifo_rd) || (issued == BURST_MAX)
                    || (fifo_rd && (issued == BURST_MAX - 8'd1)))
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (!rd_q && (occ == 3'd0)) begin
                    burst_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            issued <= 8'd0;
            rd_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= fifo_rd;
            if (clr_issued)
                issued <= 8'd0;
            else if (fifo_rd)
                issued <= issued + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) fifo_buf[i] <= '0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            occ        <= 3'd0;
            word_count <= 16'd0;
        end else begin
            if (rd_q) begin
                fifo_buf[wr_ptr] <= fifo_data_out;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 2'd1;
                word_count <= word_count + 16'd1;
            end
            case ({rd_q, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef IIITB_FIFO_DRAIN_SEQ_CHECK_EN
    logic [DATA_WIDTH-1:0] ref_word;
    logic                  ref_loaded;
    logic                  seq_err_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_word   <= '0;
            ref_loaded <= 1'b0;
            seq_err_r  <= 1'b0;
        end else if (pop) begin
            if (ref_loaded && (m_data != ref_word + DATA_WIDTH'(1)))
                seq_err_r <= 1'b1;
            ref_word   <= m_data;
            ref_loaded <= 1'b1;
        end
    end

    assign seq_err = seq_err_r;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_iiitb_fifo_drain.sv
// Scoreboard bench for iiitb_fifo_drain: a queue-based FIFO model feeds the DUT, a monitor checks the stream.
// Mirrors IIITB_FIFO_DRAIN_SEQ_CHECK_EN to know whether seq_err is expected to rise.
module tb_iiitb_fifo_drain;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       fifo_threshold = 1'b0;
    logic [7:0] fifo_data_out = 8'h00;
    logic       fifo_rd;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       busy;
    logic       burst_done;
    logic [15:0] word_count;
    logic       seq_err;

    iiitb_fifo_drain dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
        .fifo_data_out(fifo_data_out), .fifo_rd(fifo_rd),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .burst_done(burst_done),
        .word_count(word_count), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         thr_level = 1;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         rd_cyc[$];
    int         rd_pulses = 0;
    int         acc_cnt = 0;
    int         bursts = 0;
    int         acc_at_done = -1;
    logic       rd_sample = 1'b0;
    logic       ref_ok = 1'b0;
    logic [7:0] ref_w = 8'h00;
    logic       exp_seq = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_words(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(first + 8'(i));
            exp_q.push_back(first + 8'(i));
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: pops on a read seen before the edge, presents data and flags just after it
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_sample && fq.size() > 0) fifo_data_out = fq.pop_front();
        fifo_empty     = (fq.size() == 0);
        fifo_threshold = (fq.size() > 0) && (fq.size() >= thr_level);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        rd_sample = fifo_rd;
        if (rst_n) begin
            if (fifo_rd) begin
                chk("no_underflow", {31'd0, fifo_empty}, 32'd0);
                rd_pulses++;
                rd_cyc.push_back(cyc);
            end
            if (burst_done) begin
                bursts++;
                if (bursts == 1) acc_at_done = acc_cnt;
            end
            if (m_valid && m_ready) begin
                logic [7:0] w;
                chk("word_count", {16'd0, word_count}, 32'(acc_cnt[15:0]));
                chk("seq_err", {31'd0, seq_err}, {31'd0, exp_seq});
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
                end else begin
                    w = exp_q.pop_front();
                    chk("m_data", {24'd0, m_data}, {24'd0, w});
`ifdef IIITB_FIFO_DRAIN_SEQ_CHECK_EN
                    if (ref_ok && (w != ref_w + 8'd1)) exp_seq = 1'b1;
                    ref_w  = w;
                    ref_ok = 1'b1;
`endif
                end
                acc_cnt++;
            end
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        fq.delete();
        exp_q.delete();
        rd_cyc.delete();
        rd_pulses   = 0;
        acc_cnt     = 0;
        bursts      = 0;
        acc_at_done = -1;
        ref_ok      = 1'b0;
        exp_seq     = 1'b0;
        thr_level   = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && fq.size() == 0 && !busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #2;
        chk({name, "_timeout"}, {31'd0, (n >= budget)}, 32'd0);
    endtask

    initial begin
        // reset with data present in the FIFO
        load_words(8'h01, 17);
        thr_level = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", {24'd0, m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_burst_done", {31'd0, burst_done}, 32'd0);
        chk("rst_word_count", {16'd0, word_count}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // threshold burst followed by a one-word second burst
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_drained("thr", 300);
        chk("thr_rd_pulses", 32'(rd_pulses), 32'd17);
        chk("thr_bursts", 32'(bursts), 32'd2);
        chk("thr_acc_at_done", 32'(acc_at_done), 32'd16);
        chk("thr_word_count", {16'd0, word_count}, 32'd17);
        if (rd_cyc.size() >= 16) chk("thr_rd_run", 32'(rd_cyc[15] - rd_cyc[0]), 32'd15);
        else chk("thr_rd_run_size", 32'(rd_cyc.size()), 32'd16);

        // backpressure from the start
        do_reset();
        load_words(8'h01, 17);
        enable = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("bp_rd_pulses", 32'(rd_pulses), 32'd4);
        chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_m_data", {24'd0, m_data}, 32'h01);
        chk("bp_occ", {29'd0, dut.occ}, 32'd4);
        chk("bp_busy", {31'd0, busy}, 32'd1);
        m_ready = 1'b1;
        wait_drained("bp", 300);
        chk("bp_rd_total", 32'(rd_pulses), 32'd17);
        chk("bp_word_count", {16'd0, word_count}, 32'd17);

        // FIFO runs empty mid-burst
        do_reset();
        load_words(8'h20, 5);
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_drained("empty", 200);
        chk("empty_rd_pulses", 32'(rd_pulses), 32'd5);
        chk("empty_bursts", 32'(bursts), 32'd1);
        chk("empty_acc_at_done", 32'(acc_at_done), 32'd5);

        // reset in the middle of a burst
        do_reset();
        load_words(8'h40, 17);
        m_ready = 1'b1;
        enable  = 1'b1;
        begin
            int n = 0;
            while (acc_cnt < 3 && n < 100) begin
                @(posedge clk);
                n++;
            end
            chk("mid_rst_timeout", {31'd0, (n >= 100)}, 32'd0);
        end
        #2;
        chk("mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        chk("mid_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd0);
        chk("mid_word_count", {16'd0, word_count}, 32'd0);
        chk("mid_burst_done", {31'd0, burst_done}, 32'd0);
        chk("mid_m_data", {24'd0, m_data}, 32'd0);
        do_reset();
        m_ready = 1'b1;
        enable  = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("mid_idle_after", {31'd0, busy}, 32'd0);
        chk("mid_bursts_after", 32'(bursts), 32'd0);

        // sequence checker: 01, 02, 04
        do_reset();
        fq.push_back(8'h01); exp_q.push_back(8'h01);
        fq.push_back(8'h02); exp_q.push_back(8'h02);
        fq.push_back(8'h04); exp_q.push_back(8'h04);
        m_ready = 1'b1;
        enable  = 1'b1;
        wait_drained("seq", 100);
        chk("seq_err_final", {31'd0, seq_err}, {31'd0, exp_seq});
        repeat (5) @(posedge clk);
        #2;
        chk("seq_err_sticky", {31'd0, seq_err}, {31'd0, exp_seq});

        // randomized traffic, backpressure and enable
        do_reset();
        thr_level = $urandom_range(1, 6);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] v;
                v = 8'($urandom);
                fq.push_back(v);
                exp_q.push_back(v);
            end
            m_ready = ($urandom_range(0, 2) != 0);
            enable  = ($urandom_range(0, 9) != 0);
        end
        thr_level = 1;
        m_ready   = 1'b1;
        enable    = 1'b1;
        wait_drained("rnd", 1000);
        chk("rnd_word_count", {16'd0, word_count}, 32'(acc_cnt[15:0]));
        chk("rnd_exp_left", 32'(exp_q.size()), 32'd0);
        chk("rnd_seq_err", {31'd0, seq_err}, {31'd0, exp_seq});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
